// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache: 64 one-word lines.
// Ports: req_* from memory stage, rsp_rdata/stall back, mem_* line traffic.
module dcache_controller (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic        req_is_word,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rsp_rdata,
  output logic        stall,
  output logic        cache_hit,
  output logic        cache_dirty,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, WRITEBACK, REFILL, DONE
  } state_t;

  state_t      state;
  logic [31:0] data_q [64];
  logic [23:0] tag_q  [64];
  logic [63:0] valid_q;
  logic [63:0] dirty_q;

  logic [5:0]  idx;
  logic [23:0] tag;
  logic [1:0]  lane;
  logic        hit;
  logic        victim_dirty;

  assign idx          = req_addr[7:2];
  assign tag          = req_addr[31:8];
  assign lane         = req_addr[1:0];
  assign hit          = valid_q[idx] && (tag_q[idx] == tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];

  // Gated by rst_b so the pipeline is released while reset is held.
  assign stall = rst_b & req_valid & (state != DONE);

  function automatic logic [31:0] pick(
    input logic [31:0] w,
    input logic        is_word,
    input logic [1:0]  ln
  );
    logic [31:0] s;
    s = w >> {ln, 3'b000};
    return is_word ? w : {24'h0, s[7:0]};
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [31:0] d,
    input logic        is_word,
    input logic [1:0]  ln
  );
    logic [31:0] m;
    m = w;
    if (is_word) m = d;
    else m[{ln, 3'b000} +: 8] = d[7:0];
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      cache_hit   <= 1'b0;
      cache_dirty <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rsp_rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            cache_hit   <= hit;
            cache_dirty <= victim_dirty;
            if (hit) begin
              state     <= DONE;
              rsp_rdata <= pick(data_q[idx], req_is_word, lane);
            end else if (victim_dirty) begin
              state     <= WRITEBACK;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_q[idx], idx, 2'b00};
              mem_wdata <= data_q[idx];
            end else begin
              state    <= REFILL;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {tag, idx, 2'b00};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            state    <= REFILL;
            mem_we   <= 1'b0;
            mem_addr <= {tag, idx, 2'b00};
          end
        end
        REFILL: begin
          if (mem_ack) begin
            state        <= DONE;
            mem_req      <= 1'b0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            rsp_rdata    <= pick(mem_rdata, req_is_word, lane);
          end
        end
        DONE: begin
          state <= IDLE;
          if (req_valid && req_we) dirty_q[idx] <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag;
    end else if (state == DONE && req_valid && req_we) begin
      data_q[idx] <= merge(data_q[idx], req_wdata, req_is_word, lane);
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller.
// Driver queues expectations; monitors check responses and memory traffic.
module tb_dcache_controller;

  logic        clk = 0;
  logic        rst_b = 0;
  logic        req_valid = 0;
  logic        req_we = 0;
  logic        req_is_word = 0;
  logic [31:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic [31:0] rsp_rdata;
  logic        stall;
  logic        cache_hit;
  logic        cache_dirty;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata = 0;
  logic        ack_m = 0;
  logic        ack_s = 0;

  assign mem_ack = ack_m | ack_s;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_is_word (req_is_word),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_rdata   (rsp_rdata),
    .stall       (stall),
    .cache_hit   (cache_hit),
    .cache_dirty (cache_dirty),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  typedef struct {
    logic        ld;
    logic [31:0] rd;
    logic        hit;
    logic        dirty;
    int          st;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
  } mem_t;

  rsp_t exp_rsp[$];
  mem_t exp_mem[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic exp_r(input logic ld, input logic [31:0] rd,
                       input logic h, input logic d, input int st);
    rsp_t r;
    r.ld = ld; r.rd = rd; r.hit = h; r.dirty = d; r.st = st;
    exp_rsp.push_back(r);
  endtask

  task automatic exp_m(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input int lat,
                       input logic [31:0] rd);
    mem_t m;
    m.we = we; m.addr = a; m.wd = wd; m.lat = lat; m.rd = rd;
    exp_mem.push_back(m);
  endtask

  // Response monitor: a completion is req_valid with stall low.
  initial begin
    int   scnt;
    rsp_t r;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_b) scnt = 0;
      else if (req_valid) begin
        if (stall) scnt++;
        else begin
          if (exp_rsp.size() == 0) chk("rsp_unexp", 1, 0);
          else begin
            r = exp_rsp.pop_front();
            chk("rsp_hit", cache_hit, r.hit);
            chk("rsp_dirty", cache_dirty, r.dirty);
            if (r.ld) chk("rsp_rdata", rsp_rdata, r.rd);
            chk("rsp_stalls", scnt, r.st);
          end
          scnt = 0;
        end
      end
    end
  end

  // Memory model: checks each transaction, then acks after its latency.
  initial begin
    mem_t        cur;
    bit          active;
    int          cnt;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wd;
    active = 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        ack_m = 0;
        active = 0;
      end else begin
        if (ack_m) begin
          ack_m = 0;
          active = 0;
        end
        if (mem_req && !active) begin
          if (exp_mem.size() == 0) begin
            chk("mem_unexp", 1, 0);
            cur.we = mem_we; cur.addr = mem_addr; cur.wd = mem_wdata;
            cur.lat = 0; cur.rd = 0;
          end else begin
            cur = exp_mem.pop_front();
            chk("mem_we", mem_we, cur.we);
            chk("mem_addr", mem_addr, cur.addr);
            if (cur.we) chk("mem_wdata", mem_wdata, cur.wd);
          end
          s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
          active = 1;
          cnt = 0;
        end else if (active) begin
          if (!mem_req || mem_we !== s_we || mem_addr !== s_addr ||
              (s_we && mem_wdata !== s_wd))
            chk("mem_hold", {mem_req, mem_addr[30:0]}, {1'b1, s_addr[30:0]});
        end
        if (active) begin
          if (cnt == cur.lat) begin
            ack_m = 1;
            mem_rdata = cur.rd;
          end else cnt++;
        end
      end
    end
  end

  // Assumes it starts just after a rising edge; leaves the same way.
  task automatic issue(input logic we, input logic word,
                       input logic [31:0] a, input logic [31:0] d);
    int n;
    bit fin;
    n = 0;
    fin = 0;
    req_valid = 1; req_we = we; req_is_word = word;
    req_addr = a; req_wdata = d;
    while (!fin && n < 60) begin
      @(negedge clk);
      if (!stall) fin = 1;
      n++;
    end
    if (!fin) chk("req_timeout", 0, 1);
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_hit", cache_hit, 0);
    chk("rst_dirty", cache_dirty, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst_b = 1;
    @(posedge clk);
    #1;

    exp_m(0, 32'h104, 0, 3, 32'hDEADBEEF);
    exp_r(1, 32'hDEADBEEF, 0, 0, 5);
    issue(0, 1, 32'h104, 0);
    exp_r(1, 32'hDEADBEEF, 1, 0, 1);
    issue(0, 1, 32'h104, 0);
    exp_r(0, 0, 1, 0, 1);
    issue(1, 0, 32'h106, 32'h000000AA);
    exp_r(1, 32'hDEAABEEF, 1, 1, 1);
    issue(0, 1, 32'h104, 0);

    exp_m(1, 32'h104, 32'hDEAABEEF, 1, 0);
    exp_m(0, 32'h204, 0, 0, 32'hCAFEF00D);
    exp_r(1, 32'hCAFEF00D, 0, 1, 4);
    issue(0, 1, 32'h204, 0);

    // Reset in the middle of a slow refill.
    exp_m(0, 32'h304, 0, 40, 32'h0);
    req_valid = 1; req_we = 0; req_is_word = 1; req_addr = 32'h304;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 20);
    chk("refill_seen", mem_req, 1);
    @(negedge clk);
    #2 rst_b = 0;
    #1;
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_stall", stall, 0);
    req_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_b = 1;
    chk("rst_mid_hit", cache_hit, 0);

    exp_m(0, 32'h204, 0, 2, 32'h11223344);
    exp_r(1, 32'h11223344, 0, 0, 4);
    issue(0, 1, 32'h204, 0);

    // Stray ack while idle must do nothing.
    @(negedge clk);
    ack_s = 1;
    @(negedge clk);
    ack_s = 0;
    chk("stray_ack_req", mem_req, 0);
    @(posedge clk);
    #1;

    exp_m(0, 32'h408, 0, 0, 32'h0BADF00D);
    exp_r(1, 32'h0BADF00D, 0, 0, 2);
    issue(0, 1, 32'h408, 0);
    exp_r(1, 32'h0000000B, 1, 0, 1);
    issue(0, 0, 32'h40B, 0);
    exp_r(0, 0, 1, 0, 1);
    issue(1, 1, 32'h408, 32'h55667788);
    exp_r(1, 32'h00000077, 1, 1, 1);
    issue(0, 0, 32'h409, 0);
    exp_r(1, 32'h11223344, 1, 0, 1);
    issue(0, 1, 32'h204, 0);

    repeat (3) @(posedge clk);
    chk("rsp_left", exp_rsp.size(), 0);
    chk("mem_left", exp_mem.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 rst_b  in  1  reset, asynchronous, active-low.
REQ-003 req_valid  in  1  pipeline memory-stage request present; held stable while stall=1.
REQ-004 req_we  in  1  1=store, 0=load.
REQ-005 req_is_word  in  1  1=word access, 0=byte access.
REQ-006 req_addr  in  32  byte address; word access uses [1:0]=00.
REQ-007 req_wdata  in  32  store data; for a byte store, the byte is in [7:0].
REQ-008 rsp_rdata  out  32  load data; for a byte load, the byte is zero-extended into [7:0].
REQ-009 stall  out  1  freeze pipeline; request not yet complete.
REQ-010 cache_hit  out  1  lookup result of the most recent accepted request.
REQ-011 cache_dirty  out  1  dirty bit of the indexed victim line at that lookup.
REQ-012 mem_req  out  1  memory transaction request.
REQ-013 mem_we  out  1  1=line writeback, 0=line refill.
REQ-014 mem_addr  out  32  word-aligned memory address.
REQ-015 mem_wdata  out  32  writeback data.
REQ-016 mem_ack  in  1  memory completion; meaningful only while mem_req=1.
REQ-017 mem_rdata  in  32  refill data; valid in the mem_ack cycle.

Function
REQ-018 Organisation: direct-mapped, write-back, write-allocate; 64 lines of one 32-bit word; index=addr[7:2], tag=addr[31:8]; per-line valid and dirty bits.
REQ-019 FSM states: IDLE, WRITEBACK, REFILL, DONE.
REQ-020 IDLE with req_valid=1: compare tags and register cache_hit/cache_dirty. On a hit, go to DONE. On a miss with a clean or invalid victim, go to REFILL. On a miss with a valid, dirty victim, go to WRITEBACK.
REQ-021 WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_wdata=victim data. On mem_ack, go to REFILL.
REQ-022 REFILL: mem_req=1, mem_we=0, mem_addr={req tag, index, 2'b00}. On mem_ack, write mem_rdata into the line, set valid=1 and dirty=0, then go to DONE.
REQ-023 mem_req, mem_we, mem_addr and mem_wdata stay constant from assertion until the mem_ack cycle. mem_ack on the first cycle of mem_req is legal.
REQ-024 DONE, load: rsp_rdata = line word (word access), or byte addr[1:0] of the line zero-extended (byte access).
REQ-025 DONE, store: merge into the line at the clock edge leaving DONE (full word, or only byte lane addr[1:0]) and set dirty=1.
REQ-026 DONE always transitions to IDLE.
REQ-027 stall = req_valid and (state != DONE). Hit latency is therefore one stall cycle plus the DONE cycle.
REQ-028 IDLE with req_valid=0: no state change; cache_hit and cache_dirty hold their values.
REQ-029 rsp_rdata is valid only in DONE; it is undefined-but-stable elsewhere.
REQ-030 A request arriving in IDLE in the cycle directly after DONE is treated as a new request; back-to-back hits sustain one completion per two cycles.
REQ-031 A store that hits a dirty line causes no memory traffic.
REQ-032 A load that hits leaves dirty unchanged.
REQ-033 mem_ack outside WRITEBACK and REFILL is ignored.

Reset
REQ-034 While rst_b=0, asynchronously: state=IDLE, all valid and dirty bits=0, stall=0 (after req_valid gating), cache_hit=0, cache_dirty=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_rdata=0. The data and tag arrays are not reset.
REQ-035 Reset asserted mid-WRITEBACK or mid-REFILL drops mem_req immediately. The interrupted transaction is abandoned, and any later mem_ack is ignored.

Verification
REQ-036 Cold load, word, addr 0x0000_0104, memory returns 0xDEADBEEF after 3 cycles: REFILL, mem_addr=0x104, mem_we=0, stall=1 for 5 cycles; DONE gives rsp_rdata=0xDEADBEEF and cache_hit=0.
REQ-037 Repeat the load of 0x104: cache_hit=1, one stall cycle, rsp_rdata=0xDEADBEEF, mem_req never asserted.
REQ-038 Byte store 0xAA to 0x106, then word load 0x104: no memory traffic; rsp_rdata=0xDEAABEEF; the line is dirty.
REQ-039 Word load 0x0000_0204 (same index, new tag): cache_dirty=1; WRITEBACK with mem_addr=0x104, mem_wdata=0xDEAABEEF, mem_we=1; then REFILL with mem_addr=0x204.
REQ-040 Assert rst_b=0 during REFILL: mem_req=0 and stall=0 in the same cycle. After release, a load of 0x204 misses (cache_hit=0).
REQ-041 mem_ack pulsed in IDLE and mem_ack in the same cycle as the first mem_req: the first is ignored; the second completes the transaction in a single memory cycle.
